// File: rtl/filter_pipe_if.sv
// Handshake bundle for filter_pipe: input beat (x), output beat (y) and flush.
// master = the side driving beats in and taking them out, slave = the pipe.
interface filter_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  io_flush;
    logic [DATA_WIDTH-1:0] io_x_data;
    logic                  io_x_valid;
    logic                  io_x_parity;
    logic                  io_x_ready;
    logic [DATA_WIDTH-1:0] io_y_data;
    logic                  io_y_valid;
    logic                  io_y_parity;
    logic                  io_y_ready;

    modport master (
        output io_flush, io_x_data, io_x_valid, io_x_parity, io_y_ready,
        input  io_x_ready, io_y_data, io_y_valid, io_y_parity
    );

    modport slave (
        input  io_flush, io_x_data, io_x_valid, io_x_parity, io_y_ready,
        output io_x_ready, io_y_data, io_y_valid, io_y_parity
    );
endinterface

// File: rtl/filter_pipe.sv
// Elastic pipe of STAGES rotate-through-carry stages with valid/ready flow control.
// Define FILTER_PIPE_COUNT_EN to add the 16-bit io_count output-handshake counter.
module filter_pipe_stage #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_parity,
    input  logic                  ready,
    input  logic                  dn_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            data   <= '0;
            parity <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (up_valid && ready) begin
            data   <= {up_data[DATA_WIDTH-2:0], up_parity};
            parity <= up_data[DATA_WIDTH-1];
            valid  <= 1'b1;
        end else if (valid && dn_ready) begin
            valid <= 1'b0;
        end
    end
endmodule

module filter_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    filter_pipe_if.slave io
`ifdef FILTER_PIPE_COUNT_EN
    ,
    output logic [15:0] io_count
`endif
);
    // Index 0 is the input port, index k+1 is the register set of stage k.
    logic [STAGES:0][DATA_WIDTH-1:0] dat;
    logic [STAGES:0]                 par;
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0]                 rdy;

    assign dat[0]      = io.io_x_data;
    assign par[0]      = io.io_x_parity;
    assign vld_pipe[0] = io.io_x_valid;
    assign rdy[STAGES] = io.io_y_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Flattened ready chain: a bubble anywhere downstream, or the sink taking, frees stage k.
        assign rdy[k] = io.io_y_ready || !(&vld_pipe[STAGES:k+1]);

        filter_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (io.io_flush),
            .up_valid  (vld_pipe[k]),
            .up_data   (dat[k]),
            .up_parity (par[k]),
            .ready     (rdy[k]),
            .dn_ready  (rdy[k+1]),
            .valid     (vld_pipe[k+1]),
            .data      (dat[k+1]),
            .parity    (par[k+1])
        );
    end

    assign io.io_x_ready  = rdy[0] && !io.io_flush;
    assign io.io_y_valid  = vld_pipe[STAGES];
    assign io.io_y_data   = dat[STAGES];
    assign io.io_y_parity = par[STAGES];

`ifdef FILTER_PIPE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            io_count <= '0;
        else if (io.io_flush)
            io_count <= '0;
        else if (io.io_y_valid && io.io_y_ready)
            io_count <= io_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_filter_pipe.sv
// Self-checking bench for filter_pipe: table vectors, directed corner cases and a
// random run against a queue-based model ({parity,data} rotated left once per stage).
module tb_filter_pipe;
    localparam int W = 16;
    localparam int S = 2;
    typedef logic [W:0] word_t;

    typedef struct {
        logic [W-1:0] xd;
        logic         xp;
        logic [W-1:0] yd;
        logic         yp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    filter_pipe_if #(.DATA_WIDTH(W)) bus ();
`ifdef FILTER_PIPE_COUNT_EN
    logic [15:0] io_count;
`endif

    filter_pipe #(.DATA_WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
`ifdef FILTER_PIPE_COUNT_EN
        ,
        .io_count (io_count)
`endif
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // The pipe as a whole rotates the (W+1)-bit word {parity,data} left by one per stage.
    function automatic word_t model_out(input logic [W-1:0] xd, input logic xp);
        word_t q;
        q = {xp, xd};
        for (int i = 0; i < S; i++) q = {q[W-1:0], q[W]};
        return q;
    endfunction

    word_t       sb_q[$];
    logic        stall_prev = 1'b0;
    word_t       held = '0;
    logic [15:0] cnt_m = '0;

    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            stall_prev = 1'b0;
            cnt_m = '0;
        end else begin
            if (stall_prev) begin
                check("y_hold_valid", word_t'(bus.io_y_valid), word_t'(1));
                check("y_hold_data", {bus.io_y_parity, bus.io_y_data}, held);
            end
`ifdef FILTER_PIPE_COUNT_EN
            check("count", word_t'(io_count), word_t'(cnt_m));
`endif
            if (bus.io_flush) check("x_ready_flush", word_t'(bus.io_x_ready), word_t'(0));
            if (bus.io_y_valid && bus.io_y_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL y_unexpected: got beat %h expected none",
                             {bus.io_y_parity, bus.io_y_data});
                end else begin
                    check("y_beat", {bus.io_y_parity, bus.io_y_data}, sb_q.pop_front());
                end
                cnt_m++;
            end
            stall_prev = bus.io_y_valid && !bus.io_y_ready && !bus.io_flush;
            held = {bus.io_y_parity, bus.io_y_data};
            if (bus.io_flush) begin
                sb_q.delete();
                cnt_m = '0;
            end
            if (bus.io_x_valid && bus.io_x_ready)
                sb_q.push_back(model_out(bus.io_x_data, bus.io_x_parity));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic p);
        bus.io_x_valid = v;
        bus.io_x_data = d;
        bus.io_x_parity = p;
    endtask

    vec_t tbl[8];

    initial begin
        bus.io_flush = 1'b0;
        bus.io_y_ready = 1'b1;
        drive(1'b0, '0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("rst_y_valid", word_t'(bus.io_y_valid), word_t'(0));
        check("rst_y_word", {bus.io_y_parity, bus.io_y_data}, word_t'(0));
        repeat (2) cyc();
        reset = 1'b1;
        @(negedge clk);
        check("rst_x_ready", word_t'(bus.io_x_ready), word_t'(1));
        check("rst_y_valid2", word_t'(bus.io_y_valid), word_t'(0));

        // single beats: expected {yd,yp} worked out by hand from the rotate rule
        tbl[0] = '{16'h8001, 1'b1, 16'h0007, 1'b0};
        tbl[1] = '{16'h4000, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'hC000, 1'b0, 16'h0001, 1'b1};
        tbl[3] = '{16'h0000, 1'b1, 16'h0002, 1'b0};
        tbl[4] = '{16'hFFFF, 1'b0, 16'hFFFD, 1'b1};
        tbl[5] = '{16'h1234, 1'b0, 16'h48D0, 1'b0};
        tbl[6] = '{16'h7FFF, 1'b1, 16'hFFFE, 1'b1};
        tbl[7] = '{16'hA5A5, 1'b1, 16'h9697, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(1'b1, tbl[i].xd, tbl[i].xp);
            @(negedge clk);
            check("tbl_x_ready", word_t'(bus.io_x_ready), word_t'(1));
            cyc();
            drive(1'b0, '0, 1'b0);
            for (int j = 1; j < S; j++) begin
                @(negedge clk);
                check("tbl_early", word_t'(bus.io_y_valid), word_t'(0));
                cyc();
            end
            @(negedge clk);
            check("tbl_valid", word_t'(bus.io_y_valid), word_t'(1));
            check("tbl_word", {bus.io_y_parity, bus.io_y_data}, {tbl[i].yp, tbl[i].yd});
            cyc();
            @(negedge clk);
            check("tbl_one_cycle", word_t'(bus.io_y_valid), word_t'(0));
        end

        // back-to-back stream of 0x0001..0x0008
        cyc();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i + 1), 1'b0);
            @(negedge clk);
            check("stream_x_ready", word_t'(bus.io_x_ready), word_t'(1));
            if (i >= S) check("stream_b2b", word_t'(bus.io_y_valid), word_t'(1));
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            check("stream_tail", word_t'(bus.io_y_valid), word_t'(1));
            cyc();
        end
        @(negedge clk);
        check("stream_drained", word_t'(sb_q.size()), word_t'(0));

        // backpressure with a full pipe and a third beat waiting
        cyc();
        bus.io_y_ready = 1'b0;
        drive(1'b1, 16'h4000, 1'b0);
        cyc();
        drive(1'b1, 16'hC000, 1'b0);
        cyc();
        drive(1'b1, 16'h1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_x_ready", word_t'(bus.io_x_ready), word_t'(0));
            check("bp_y_valid", word_t'(bus.io_y_valid), word_t'(1));
            check("bp_y_word", {bus.io_y_parity, bus.io_y_data}, {1'b1, 16'h0000});
            cyc();
        end
        bus.io_y_ready = 1'b1;
        cyc();
        drive(1'b0, '0, 1'b0);
        repeat (S + 3) cyc();
        check("bp_drained", word_t'(sb_q.size()), word_t'(0));

        // flush while full with a concurrent input beat
        bus.io_y_ready = 1'b0;
        drive(1'b1, 16'h0F0F, 1'b0);
        cyc();
        drive(1'b1, 16'hF0F0, 1'b1);
        cyc();
        bus.io_flush = 1'b1;
        drive(1'b1, 16'hAAAA, 1'b1);
        cyc();
        bus.io_flush = 1'b0;
        bus.io_y_ready = 1'b1;
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("flush_y_valid", word_t'(bus.io_y_valid), word_t'(0));
        check("flush_x_ready", word_t'(bus.io_x_ready), word_t'(1));
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check("flush_empty", word_t'(bus.io_y_valid), word_t'(0));
        end

        // asynchronous reset between edges in the middle of a stream
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'($urandom), 1'($urandom));
            cyc();
        end
        #1 reset = 1'b0;
        #1;
        check("arst_y_valid", word_t'(bus.io_y_valid), word_t'(0));
        check("arst_y_word", {bus.io_y_parity, bus.io_y_data}, word_t'(0));
`ifdef FILTER_PIPE_COUNT_EN
        check("arst_count", word_t'(io_count), word_t'(0));
`endif
        drive(1'b0, '0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("arst_x_ready", word_t'(bus.io_x_ready), word_t'(1));
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("arst_empty", word_t'(bus.io_y_valid), word_t'(0));
        end

        // random traffic, backpressure and occasional flushes
        for (int i = 0; i < 600; i++) begin
            cyc();
            drive($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom));
            bus.io_y_ready = $urandom_range(0, 3) != 0;
            bus.io_flush = $urandom_range(0, 49) == 0;
        end
        cyc();
        drive(1'b0, '0, 1'b0);
        bus.io_flush = 1'b0;
        bus.io_y_ready = 1'b1;
        repeat (S + 3) cyc();
        check("rand_drained", word_t'(sb_q.size()), word_t'(0));

`ifdef FILTER_PIPE_COUNT_EN
        // counter wraps: 65537 handshakes from reset leave 1
        #1 reset = 1'b0;
        cyc();
        reset = 1'b1;
        drive(1'b1, 16'h0001, 1'b0);
        repeat (65537) cyc();
        drive(1'b0, '0, 1'b0);
        repeat (S + 2) cyc();
        check("count_wrap", word_t'(io_count), word_t'(16'h0001));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
